// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and oversampling constants.
// Used by uart_rx_main (optional parity state enabled by UART_RX_PARITY_EN).
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned START_MID  = 7;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick generator: one-clk tick every BAUD_DIV clocks.
// Shared between the UART TX and RX sides; never resynchronised to the line.
module uart_baud_gen #(
   parameter int unsigned BAUD_DIV = 650
) (
   input  logic clk,
   input  logic reset_n,
   output logic o_tick
);

   localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_wrap;

   assign w_wrap = (r_cnt == CW'(BAUD_DIV - 1));
   assign o_tick = w_wrap;

   // Count 0..BAUD_DIV-1 and wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_rx_main.sv
// UART receiver, 16x oversampled, LSB first, registered outputs.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits;
// otherwise the frame is start + DBIT + stop and parity_err is tied low.
module uart_rx_main
   import uart_pkg::*;
#(
   parameter int unsigned DBIT     = 8,
   parameter int unsigned SB_TICK  = 16,
   parameter int unsigned BAUD_DIV = 650
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            rx,
   output logic [DBIT-1:0] rx_dout,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            parity_err
);

   // Stop-bit counting needs up to 32 ticks for 2 stop bits.
   localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
   localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   logic            w_tick;
   logic            r_sync1, r_sync2, r_prev;
   uart_state_e     r_state, w_state_d;
   logic [SW-1:0]   r_s, w_s_d;
   logic [NW-1:0]   r_n, w_n_d;
   logic [DBIT-1:0] r_b, w_b_d;
   logic [DBIT-1:0] r_dout, w_dout_d;
   logic            r_done, w_done_d;
   logic            r_ferr, w_ferr_d;
   logic            r_perr, w_perr_d;
   logic            w_stop_end;
`ifdef UART_RX_PARITY_EN
   logic            r_par, w_par_d;
`endif

   uart_baud_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .o_tick  (w_tick)
   );

   assign rx_dout      = r_dout;
   assign rx_done_tick = r_done;
   assign frame_err    = r_ferr;
   assign parity_err   = r_perr;

   assign w_stop_end = (r_state == StStop) && w_tick && (r_s == SW'(SB_TICK - 1));

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next state plus tick counter, bit counter and shift register.
   always_comb begin
      w_state_d = r_state;
      w_s_d     = r_s;
      w_n_d     = r_n;
      w_b_d     = r_b;
`ifdef UART_RX_PARITY_EN
      w_par_d   = r_par;
`endif
      case (r_state)
         StIdle: begin
            // Only a real falling edge starts a frame; a line stuck low does not.
            if (r_prev && !r_sync2) begin
               w_state_d = StStart;
               w_s_d     = '0;
            end
         end
         StStart: begin
            if (w_tick) begin
               if (r_s == SW'(START_MID)) begin
                  w_s_d = '0;
                  if (!r_sync2) begin
                     w_state_d = StData;
                     w_n_d     = '0;
                  end else begin
                     w_state_d = StIdle;
                  end
               end else begin
                  w_s_d = r_s + SW'(1);
               end
            end
         end
         StData: begin
            if (w_tick) begin
               if (r_s == SW'(OVERSAMPLE - 1)) begin
                  w_s_d = '0;
                  w_b_d = {r_sync2, r_b[DBIT-1:1]};
                  if (r_n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                     w_state_d = StParity;
`else
                     w_state_d = StStop;
`endif
                  end else begin
                     w_n_d = r_n + NW'(1);
                  end
               end else begin
                  w_s_d = r_s + SW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (w_tick) begin
               if (r_s == SW'(OVERSAMPLE - 1)) begin
                  w_s_d     = '0;
                  w_par_d   = r_sync2;
                  w_state_d = StStop;
               end else begin
                  w_s_d = r_s + SW'(1);
               end
            end
         end
`endif
         StStop: begin
            if (w_tick) begin
               if (r_s == SW'(SB_TICK - 1)) begin
                  w_s_d     = '0;
                  w_state_d = StIdle;
               end else begin
                  w_s_d = r_s + SW'(1);
               end
            end
         end
         default: begin
            w_state_d = StIdle;
            w_s_d     = '0;
         end
      endcase
   end

   // Output decode: deliver the word or flag a framing error at mid-stop.
   always_comb begin
      w_dout_d = r_dout;
      w_done_d = 1'b0;
      w_ferr_d = 1'b0;
      w_perr_d = 1'b0;
      if (w_stop_end) begin
         if (r_sync2) begin
            w_dout_d = r_b;
            w_done_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_perr_d = ^{r_b, r_par};
`endif
         end else begin
            w_ferr_d = 1'b1;
         end
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s    <= '0;
         r_n    <= '0;
         r_b    <= '0;
         r_dout <= '0;
         r_done <= 1'b0;
         r_ferr <= 1'b0;
         r_perr <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par  <= 1'b0;
`endif
      end else begin
         r_s    <= w_s_d;
         r_n    <= w_n_d;
         r_b    <= w_b_d;
         r_dout <= w_dout_d;
         r_done <= w_done_d;
         r_ferr <= w_ferr_d;
         r_perr <= w_perr_d;
`ifdef UART_RX_PARITY_EN
         r_par  <= w_par_d;
`endif
      end
   end

endmodule
